// File: rtl/soc_periph_router.sv
// Single-outstanding request router from the SoC master port to the fixed peripheral set.
// Unmapped addresses and stalled accesses are answered locally with an error response.
module soc_periph_router #(
  parameter int NumSlaves     = 11,
  parameter int AddrWidth     = 64,
  parameter int DataWidth     = 64,
  parameter int TimeoutCycles = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_i,
  input  logic                           we_i,
  input  logic [AddrWidth-1:0]           addr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic [DataWidth/8-1:0]         be_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           err_o,
  output logic [NumSlaves-1:0]           slv_req_o,
  output logic                           slv_we_o,
  output logic [AddrWidth-1:0]           slv_addr_o,
  output logic [DataWidth-1:0]           slv_wdata_o,
  output logic [DataWidth/8-1:0]         slv_be_o,
  input  logic [NumSlaves-1:0]           slv_gnt_i,
  input  logic [NumSlaves-1:0]           slv_rvalid_i,
  input  logic [NumSlaves*DataWidth-1:0] slv_rdata_i
);

  localparam int IdxW = $clog2(NumSlaves);
  localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  // Index order matches the SoC slave enum: CLIC, DRAM, GPIO, Eth, SPI, Timer, UART, PLIC, CLINT, ROM, Debug.
  localparam logic [AddrWidth-1:0] MAP_BASE [NumSlaves] = '{
    64'h0000_0000_5000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000,
    64'h0000_0000_3000_0000, 64'h0000_0000_2000_0000, 64'h0000_0000_1800_0000,
    64'h0000_0000_1000_0000, 64'h0000_0000_0C00_0000, 64'h0000_0000_0200_0000,
    64'h0000_0000_0001_0000, 64'h0000_0000_0000_0000
  };
  localparam logic [AddrWidth-1:0] MAP_LEN [NumSlaves] = '{
    64'h0000_0000_03FF_FFFF, 64'h0000_0000_4000_0000, 64'h0000_0000_0000_1000,
    64'h0000_0000_0001_0000, 64'h0000_0000_0080_0000, 64'h0000_0000_0000_1000,
    64'h0000_0000_0000_1000, 64'h0000_0000_03FF_FFFF, 64'h0000_0000_000C_0000,
    64'h0000_0000_0001_0000, 64'h0000_0000_0000_1000
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Returns {hit, index}; the upper bound is computed one bit wider so base+len never wraps.
  function automatic logic [IdxW:0] decode(input logic [AddrWidth-1:0] a);
    logic            hit;
    logic [IdxW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      if ((a >= MAP_BASE[i]) &&
          ({1'b0, a} < ({1'b0, MAP_BASE[i]} + {1'b0, MAP_LEN[i]}))) begin
        hit = 1'b1;
        idx = IdxW'(i);
      end
    end
    return {hit, idx};
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IdxW-1:0]         r_idx;
  logic [CntW-1:0]         r_cnt;
  logic                    r_we;
  logic [AddrWidth-1:0]    r_addr;
  logic [DataWidth-1:0]    r_wdata;
  logic [DataWidth/8-1:0]  r_be;
  logic                    r_rvalid;
  logic                    r_err;
  logic [DataWidth-1:0]    r_rdata;

  logic [IdxW:0]           w_dec;
  logic                    w_hit;
  logic                    w_gnt;
  logic                    w_timeout;
  logic                    w_rsp_ok;
  logic                    w_rsp_err;
  logic [DataWidth-1:0]    w_slice;

  assign w_dec     = decode(addr_i);
  assign w_hit     = w_dec[IdxW];
  assign w_gnt     = ~rst_i & (r_state == S_IDLE) & req_i;
  assign w_timeout = (r_cnt == CntW'(TimeoutCycles - 1));
  assign w_slice   = slv_rdata_i[r_idx*DataWidth +: DataWidth];

  assign gnt_o       = w_gnt;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign slv_we_o    = r_we;
  assign slv_addr_o  = r_addr;
  assign slv_wdata_o = r_wdata;
  assign slv_be_o    = r_be;
  assign slv_req_o   = (r_state == S_REQ) ? (NumSlaves'(1) << r_idx) : '0;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a real response in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_rsp_ok    = 1'b0;
    w_rsp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt) begin
          w_state_nxt = w_hit ? S_REQ : S_ERR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_rsp_err   = 1'b1;
        end else if (slv_gnt_i[r_idx]) begin
          w_state_nxt = S_RSP;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_RSP: begin
        if (slv_rvalid_i[r_idx]) begin
          w_state_nxt = S_IDLE;
          w_rsp_ok    = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_rsp_err   = 1'b1;
        end else begin
          w_state_nxt = S_RSP;
        end
      end
      S_ERR: begin
        w_state_nxt = S_IDLE;
        w_rsp_err   = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture and timeout counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (w_gnt) begin
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_be    <= be_i;
      r_idx   <= w_dec[IdxW-1:0];
      r_cnt   <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_RSP)) begin
      r_cnt   <= r_cnt + CntW'(1);
    end else begin
      r_cnt   <= r_cnt;
    end
  end

  // Registered upstream response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rsp_ok | w_rsp_err;
      r_err    <= w_rsp_err;
      r_rdata  <= (w_rsp_ok && !r_we) ? w_slice : '0;
    end
  end

endmodule
